// File: rtl/cv32e41s_tcm_dualport.sv
// rtl/cv32e41s_tcm_dualport.sv - dual-port tightly coupled memory with read-first access
// Port A wins same-word collisions when a write is involved; responses pipelined READ_LATENCY deep.
module cv32e41s_tcm_dualport #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 4096,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    a_req_i,
  output logic                    a_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   a_addr_i,
  input  logic                    a_we_i,
  input  logic [DATA_WIDTH/8-1:0] a_be_i,
  input  logic [DATA_WIDTH-1:0]   a_wdata_i,
  output logic                    a_rvalid_o,
  output logic [DATA_WIDTH-1:0]   a_rdata_o,
  output logic                    a_err_o,
  input  logic                    b_req_i,
  output logic                    b_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   b_addr_i,
  input  logic                    b_we_i,
  input  logic [DATA_WIDTH/8-1:0] b_be_i,
  input  logic [DATA_WIDTH-1:0]   b_wdata_i,
  output logic                    b_rvalid_o,
  output logic [DATA_WIDTH-1:0]   b_rdata_o,
  output logic                    b_err_o
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TOP   = OFF_W + IDX_W;

  logic [1:0]            req, we, gnt, oor;
  logic                  coll;
  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [BE_W-1:0]       be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [IDX_W-1:0]      idx   [2];

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [1:0]            s1_valid_d, s1_valid_q, s1_err_d, s1_err_q;
  logic [DATA_WIDTH-1:0] s1_rdata_d [2];
  logic [DATA_WIDTH-1:0] s1_rdata_q [2];

  logic [1:0]            rsp_valid, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata [2];

  assign req      = {b_req_i, a_req_i};
  assign we       = {b_we_i, a_we_i};
  assign addr[0]  = a_addr_i;
  assign addr[1]  = b_addr_i;
  assign be[0]    = a_be_i;
  assign be[1]    = b_be_i;
  assign wdata[0] = a_wdata_i;
  assign wdata[1] = b_wdata_i;

  for (genvar p = 0; p < 2; p++) begin : g_port
    if (ADDR_WIDTH > TOP) begin : g_hi
      assign oor[p] = |addr[p][ADDR_WIDTH-1:TOP];
    end else begin : g_nohi
      assign oor[p] = 1'b0;
    end
    assign idx[p] = addr[p][TOP-1:OFF_W];
  end

  always_comb begin
    coll   = req[0] & req[1] & (idx[0] == idx[1]) & (we[0] | we[1]);
    gnt[0] = rst_ni & req[0];
    gnt[1] = rst_ni & req[1] & ~coll;
  end

  // Memory is never reset; out-of-range writes are dropped
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < int'(BE_W); k++) begin
        if (gnt[p] && we[p] && !oor[p] && be[p][k]) begin
          mem_q[idx[p]][8*k +: 8] <= wdata[p][8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      s1_valid_d[p] = gnt[p];
      s1_err_d[p]   = gnt[p] & oor[p];
      s1_rdata_d[p] = (gnt[p] && !we[p] && !oor[p]) ? mem_q[idx[p]] : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= '0;
      s1_err_q   <= '0;
      for (int p = 0; p < 2; p++) s1_rdata_q[p] <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      for (int p = 0; p < 2; p++) s1_rdata_q[p] <= s1_rdata_d[p];
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [1:0]            s2_valid_d, s2_valid_q, s2_err_d, s2_err_q;
    logic [DATA_WIDTH-1:0] s2_rdata_d [2];
    logic [DATA_WIDTH-1:0] s2_rdata_q [2];

    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_err_d   = s1_err_q;
      for (int p = 0; p < 2; p++) s2_rdata_d[p] = s1_rdata_q[p];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s2_valid_q <= '0;
        s2_err_q   <= '0;
        for (int p = 0; p < 2; p++) s2_rdata_q[p] <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_err_q   <= s2_err_d;
        for (int p = 0; p < 2; p++) s2_rdata_q[p] <= s2_rdata_d[p];
      end
    end

    assign rsp_valid    = s2_valid_q;
    assign rsp_err      = s2_err_q;
    assign rsp_rdata[0] = s2_rdata_q[0];
    assign rsp_rdata[1] = s2_rdata_q[1];
  end else begin : g_lat1
    assign rsp_valid    = s1_valid_q;
    assign rsp_err      = s1_err_q;
    assign rsp_rdata[0] = s1_rdata_q[0];
    assign rsp_rdata[1] = s1_rdata_q[1];
  end

  assign a_gnt_o    = gnt[0];
  assign b_gnt_o    = gnt[1];
  assign a_rvalid_o = rsp_valid[0];
  assign b_rvalid_o = rsp_valid[1];
  assign a_err_o    = rsp_err[0];
  assign b_err_o    = rsp_err[1];
  assign a_rdata_o  = rsp_rdata[0];
  assign b_rdata_o  = rsp_rdata[1];

endmodule

// File: tb/tb_cv32e41s_tcm_dualport.sv
// tb/tb_cv32e41s_tcm_dualport.sv - directed bench for cv32e41s_tcm_dualport
// Two instances: default READ_LATENCY=1, and READ_LATENCY=2 for the reset-flush scenario.
module tb_cv32e41s_tcm_dualport;

  logic        clk;
  logic        rst_n, rst2_n;
  logic        a_req, a_gnt, a_we, a_rvalid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;
  logic        b_req, b_gnt, b_we, b_rvalid, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;

  logic        c_req, c_gnt, c_we, c_rvalid, c_err;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [3:0]  c_be;
  logic        d_req, d_gnt, d_we, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;

  int checks   = 0;
  int failures = 0;

  cv32e41s_tcm_dualport u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(a_req), .a_gnt_o(a_gnt), .a_addr_i(a_addr), .a_we_i(a_we), .a_be_i(a_be),
    .a_wdata_i(a_wdata), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata), .a_err_o(a_err),
    .b_req_i(b_req), .b_gnt_o(b_gnt), .b_addr_i(b_addr), .b_we_i(b_we), .b_be_i(b_be),
    .b_wdata_i(b_wdata), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata), .b_err_o(b_err)
  );

  cv32e41s_tcm_dualport #(.READ_LATENCY(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst2_n),
    .a_req_i(c_req), .a_gnt_o(c_gnt), .a_addr_i(c_addr), .a_we_i(c_we), .a_be_i(c_be),
    .a_wdata_i(c_wdata), .a_rvalid_o(c_rvalid), .a_rdata_o(c_rdata), .a_err_o(c_err),
    .b_req_i(d_req), .b_gnt_o(d_gnt), .b_addr_i(d_addr), .b_we_i(d_we), .b_be_i(d_be),
    .b_wdata_i(d_wdata), .b_rvalid_o(d_rvalid), .b_rdata_o(d_rdata), .b_err_o(d_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic req, input logic wr, input logic [31:0] ad,
                       input logic [3:0] bm, input logic [31:0] wd);
    a_req = req; a_we = wr; a_addr = ad; a_be = bm; a_wdata = wd;
  endtask

  task automatic drv_b(input logic req, input logic wr, input logic [31:0] ad,
                       input logic [3:0] bm, input logic [31:0] wd);
    b_req = req; b_we = wr; b_addr = ad; b_be = bm; b_wdata = wd;
  endtask

  task automatic drv_c(input logic req, input logic wr, input logic [31:0] ad,
                       input logic [31:0] wd);
    c_req = req; c_we = wr; c_addr = ad; c_be = 4'hF; c_wdata = wd;
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    drv_a(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    drv_b(1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
    drv_c(1'b1, 1'b0, 32'h0, 32'h0);
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_be = '0; d_wdata = '0;
    #3;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_a_rsp", {a_rvalid, a_err, a_rdata}, 0);
    chk("rst_b_rsp", {b_rvalid, b_err, b_rdata}, 0);
    chk("rst_c_rsp", {c_rvalid, c_err, c_rdata}, 0);

    @(negedge clk);
    rst_n = 1'b1; rst2_n = 1'b1;
    drv_a(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    drv_b(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    c_req = 1'b0;
    #1 chk("first_a_gnt", a_gnt, 1);
    step;
    chk("wr_rsp", {a_rvalid, a_err, a_rdata}, {1'b1, 1'b0, 32'h0});

    drv_a(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drv_b(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    #1 chk("rd_b_gnt", b_gnt, 1);
    step;
    chk("rd_b_rsp", {b_rvalid, b_err, b_rdata}, {1'b1, 1'b0, 32'hDEADBEEF});
    chk("a_idle_rsp", {a_rvalid, a_err, a_rdata}, 0);

    drv_b(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drv_a(1'b1, 1'b1, 32'h80, 4'hF, 32'h11223344);
    step;
    chk("b_idle_rsp", {b_rvalid, b_err, b_rdata}, 0);
    drv_a(1'b1, 1'b1, 32'h80, 4'b0010, 32'h0000AA00);
    step;
    drv_a(1'b1, 1'b0, 32'h80, 4'hF, 32'h0);
    step;
    chk("be_merge", {a_rvalid, a_err, a_rdata}, {1'b1, 1'b0, 32'h1122AA44});
    drv_a(1'b1, 1'b1, 32'h82, 4'h0, 32'hFFFFFFFF);
    step;
    chk("be0_rsp", {a_rvalid, a_err, a_rdata}, {1'b1, 1'b0, 32'h0});
    drv_a(1'b1, 1'b0, 32'h80, 4'hF, 32'h0);
    step;
    chk("be0_nochange", a_rdata, 32'h1122AA44);

    drv_a(1'b1, 1'b1, 32'h40, 4'hF, 32'h55);
    drv_b(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
    #1 chk("coll_gnt", {a_gnt, b_gnt}, 2'b10);
    step;
    chk("coll_b_none", b_rvalid, 0);
    drv_a(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1 chk("coll_b_later", b_gnt, 1);
    step;
    chk("coll_b_rsp", {b_rvalid, b_rdata}, {1'b1, 32'h55});
    drv_b(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    drv_a(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
    step;
    drv_a(1'b1, 1'b1, 32'h40, 4'hF, 32'h99);
    chk("rd_before_wr", a_rdata, 32'h55);
    step;
    drv_a(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
    step;
    chk("rd_after_wr", a_rdata, 32'h99);

    drv_b(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
    #1 chk("same_rd_gnt", {a_gnt, b_gnt}, 2'b11);
    step;
    chk("same_rd_data", {a_rdata, b_rdata}, {32'h99, 32'h99});

    drv_a(1'b1, 1'b1, 32'h100, 4'hF, 32'hCAFEF00D);
    drv_b(1'b1, 1'b0, 32'h13, 4'hF, 32'h0);
    #1 chk("diff_gnt", {a_gnt, b_gnt}, 2'b11);
    step;
    chk("offset_ignored", b_rdata, 32'hDEADBEEF);
    drv_a(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drv_b(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    step;
    chk("par_wr_data", b_rdata, 32'hCAFEF00D);
    drv_b(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    drv_a(1'b1, 1'b0, 32'h4000, 4'hF, 32'h0);
    #1 chk("oor_gnt", a_gnt, 1);
    step;
    chk("oor_rd_rsp", {a_rvalid, a_err, a_rdata}, {1'b1, 1'b1, 32'h0});
    drv_a(1'b1, 1'b1, 32'h4010, 4'hF, 32'h12345678);
    step;
    chk("oor_wr_rsp", {a_rvalid, a_err, a_rdata}, {1'b1, 1'b1, 32'h0});
    drv_a(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    step;
    chk("oor_no_alias", {a_err, a_rdata}, {1'b0, 32'hDEADBEEF});
    drv_a(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step;
    chk("a_back_idle", {a_rvalid, a_err, a_rdata}, 0);

    for (int i = 0; i < 4; i++) begin
      drv_c(1'b1, 1'b1, 32'(i * 4), 32'hA0 + 32'(i));
      step;
    end
    drv_c(1'b1, 1'b0, 32'h0, 32'h0);
    step;
    drv_c(1'b1, 1'b0, 32'h4, 32'h0);
    step;
    chk("l2_rsp1", {c_rvalid, c_err, c_rdata}, {1'b1, 1'b0, 32'hA0});
    drv_c(1'b1, 1'b0, 32'h8, 32'h0);
    step;
    chk("l2_rsp2", {c_rvalid, c_err, c_rdata}, {1'b1, 1'b0, 32'hA1});
    drv_c(1'b1, 1'b0, 32'hC, 32'h0);
    #2 rst2_n = 1'b0;
    #1;
    chk("l2_rst_rsp", {c_rvalid, c_err, c_rdata}, 0);
    chk("l2_rst_gnt", c_gnt, 0);
    c_req = 1'b0;
    step;
    step;
    @(negedge clk);
    rst2_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk($sformatf("l2_flushed_%0d", i), {c_rvalid, c_err, c_rdata}, 0);
    end
    drv_c(1'b1, 1'b0, 32'h8, 32'h0);
    step;
    c_req = 1'b0;
    chk("l2_lat_not_1", c_rvalid, 0);
    step;
    chk("l2_mem_kept", {c_rvalid, c_err, c_rdata}, {1'b1, 1'b0, 32'hA2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cv32e41s_tcm_dualport.md
CV32E41S_TCM_DUALPORT -- requirements
Module: cv32e41s_tcm_dualport

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (multiple of 8, at least 8).
REQ-002 SHALL have parameter DEPTH, default 4096, number of words (power of two, at least 2).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, byte-address width on each port.
REQ-004 SHALL have parameter READ_LATENCY, default 1, cycles from grant to response (1 or 2 only).
REQ-005 SHALL have ports clk_i (input, 1 bit, single clock) and rst_ni (input, 1 bit, asynchronous active-low reset).
REQ-006 For each port P in {a, b}, the block SHALL provide the following signals:
- P_req_i: input, 1 bit, request.
- P_gnt_o: output, 1 bit, grant.
- P_addr_i: input, ADDR_WIDTH bits, byte address.
- P_we_i: input, 1 bit, write enable.
- P_be_i: input, DATA_WIDTH/8 bits, byte enables.
- P_wdata_i: input, DATA_WIDTH bits, write data.
- P_rvalid_o: output, 1 bit, response valid.
- P_rdata_o: output, DATA_WIDTH bits, read data.
- P_err_o: output, 1 bit, response error.

Function
REQ-007 Word index SHALL be P_addr_i[log2(DATA_WIDTH/8)+log2(DEPTH)-1 : log2(DATA_WIDTH/8)]; low byte-offset bits SHALL be ignored.
REQ-008 A request SHALL be out of range when any P_addr_i bit above the word-index field is 1.
REQ-009 Transfer SHALL occur on a rising clk_i edge where P_req_i and P_gnt_o are both 1; a requester holds req, addr, we, be and wdata stable until granted.
REQ-010 P_gnt_o SHALL be combinational and SHALL be 1 whenever P_req_i=1, except in the collision case of REQ-013.
REQ-011 A granted write SHALL update only the bytes with P_be_i=1; a write with be=0 SHALL leave memory unchanged but still produce a response.
REQ-012 A granted read SHALL return the word content as it was before any write in the same cycle (read-first).
REQ-013 Collision: a_req_i=1, b_req_i=1, same word index, and at least one we=1 -> port A granted, b_gnt_o=0 that cycle; B is granted on a later cycle once the condition clears.
REQ-014 Both ports reading the same word SHALL both be granted and both receive identical data.
REQ-015 Each granted transfer SHALL produce exactly one P_rvalid_o pulse exactly READ_LATENCY cycles after the grant edge, in grant order, with no backpressure.
REQ-016 Back-to-back grants SHALL give back-to-back responses; throughput SHALL be one transfer per port per cycle.
REQ-017 Write responses SHALL have P_rdata_o=0 and P_err_o=0.
REQ-018 Out-of-range transfers SHALL be granted, SHALL not access memory, and SHALL respond with P_err_o=1 and P_rdata_o=0.
REQ-019 P_rdata_o and P_err_o SHALL be 0 in cycles where P_rvalid_o=0.
REQ-020 With READ_LATENCY=2, the second stage SHALL be a register copy of the first; no memory access SHALL be repeated.

Reset
REQ-021 While rst_ni=0, the following outputs SHALL be 0 asynchronously: a/b_rvalid_o, a/b_rdata_o, a/b_err_o, and all response pipeline registers.
REQ-022 P_gnt_o SHALL be 0 while rst_ni=0.
REQ-023 Memory contents SHALL NOT be reset.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight responses; no rvalid SHALL appear for them after reset release.
REQ-025 First grant SHALL be possible on the first rising edge after rst_ni deasserts.

Verification
REQ-026 Write a_addr=0x10, be=4'hF, wdata=0xDEADBEEF, then read b_addr=0x10 -> b_rvalid one cycle after grant (READ_LATENCY=1), b_rdata=0xDEADBEEF, b_err=0.
REQ-027 Write 0x11223344 to word 0x20, then write be=4'b0010, wdata=0x0000AA00, then read -> rdata=0x1122AA44.
REQ-028 Same cycle: A writes 0x55 to 0x40 and B reads 0x40 ->
- a_gnt=1 and b_gnt=0 in that cycle.
- b_gnt=1 in the next cycle.
- B response returns 0x55.
REQ-029 Same cycle: A reads 0x40 while A also writes 0x99 with old value 0x55 (read-first) -> read response returns 0x55; a following read returns 0x99.
REQ-030 DEPTH=4096, DATA_WIDTH=32, read a_addr=0x4000 -> a_gnt=1, a_rvalid=1, a_err=1, a_rdata=0.
REQ-031 READ_LATENCY=2: issue reads on 4 consecutive cycles, assert rst_ni=0 after the second response -> remaining responses never appear and all outputs read 0.
